uop_truth_table_checker: RTL and testbench

Synthesizable self-checking stimulus/response engine for small combinational gate blocks (uop_nxor and similar). On start it drives every minterm of an N-input DUT in ascending order and waits a settle interval. It then samples the DUT's single output and compares it against a parameterised truth table. It reports pass/fail, a failure count and the first failing minterm, so gate labs run in hardware without a simulator bench.

---
 rtl/uop_truth_table_checker_if.sv | 25 ++
 rtl/uop_truth_table_checker.sv | 118 +++++++++++
 tb/tb_uop_truth_table_checker.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uop_truth_table_checker_if.sv
// Bus between the truth-table checker and the environment: the gate under test,
// the start control and the sweep result.
interface uop_truth_table_checker_if #(
  parameter int N = 2
);
  logic         start;
  logic [N-1:0] dut_in;
  logic         dut_out;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   fail_count;
  logic [N-1:0] first_fail_mt;
  logic         first_fail_valid;

  modport master (
    input  start, dut_out,
    output dut_in, busy, done, pass, fail_count, first_fail_mt, first_fail_valid
  );

  modport slave (
    output start, dut_out,
    input  dut_in, busy, done, pass, fail_count, first_fail_mt, first_fail_valid
  );
endinterface

// File: rtl/uop_truth_table_checker.sv
// Sweeps every minterm of an N-input gate, lets each settle, and compares the
// sampled response with the TRUTH table, keeping a failure count and first failing minterm.
module uop_truth_table_checker #(
  parameter int               N      = 2,
  parameter logic [2**N-1:0]  TRUTH  = 4'b1001,
  parameter int               SETTLE = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  uop_truth_table_checker_if.master   bus
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   mt_q, mt_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [N:0]     fail_q, fail_d;
  logic [N-1:0]   ffmt_q, ffmt_d;
  logic           ffv_q, ffv_d;
  logic           mismatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mt_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
      ffmt_q  <= '0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ffmt_q  <= ffmt_d;
      ffv_q   <= ffv_d;
    end
  end

  assign mismatch = (bus.dut_out != TRUTH[mt_q]);

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    ffmt_d  = ffmt_q;
    ffv_d   = ffv_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = DRIVE;
          mt_d    = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = '0;
          ffmt_d  = '0;
          ffv_d   = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          fail_d = fail_q + (N+1)'(1);
          if (!ffv_q) begin
            ffmt_d = mt_q;
            ffv_d  = 1'b1;
          end
        end
        // pass must reflect the comparison made on this very edge
        if (mt_q == {N{1'b1}}) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_d == '0);
        end else begin
          state_d = DRIVE;
          mt_d    = mt_q + N'(1);
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dut_in           = mt_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.fail_count       = fail_q;
  assign bus.first_fail_mt    = ffmt_q;
  assign bus.first_fail_valid = ffv_q;

endmodule

// File: tb/tb_uop_truth_table_checker.sv
// Scoreboard bench: each sweep pushes its expected verdict; a negedge monitor
// checks the minterm sequence and pops/compares the verdict when done rises.
module tb_uop_truth_table_checker;

  localparam int         N      = 2;
  localparam logic [3:0] TRUTH  = 4'b1001;
  localparam int         SETTLE = 2;
  localparam int         SWEEP  = (2**N) * (SETTLE + 1);

  typedef struct {
    logic pass;
    int   fails;
    logic ffv;
    int   ffmt;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] dutTable;
  exp_t       sbq[$];
  int         checks;
  int         failures;

  uop_truth_table_checker_if #(.N(N)) bus ();

  uop_truth_table_checker #(.N(N), .TRUTH(TRUTH), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // The gate under test is an arbitrary 2-input function held in dutTable.
  assign bus.dut_out = dutTable[bus.dut_in];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: tracks edges since the start edge and consumes the scoreboard on done.
  logic prevBusy, prevDone, tracking;
  int   edgeCnt;
  initial begin
    prevBusy = 1'b0;
    prevDone = 1'b0;
    tracking = 1'b0;
    edgeCnt  = 0;
  end

  always @(negedge clk) begin
    if (reset) begin
      prevBusy = 1'b0;
      prevDone = 1'b0;
      tracking = 1'b0;
    end else begin
      if (bus.busy && !prevBusy) begin
        tracking = 1'b1;
        edgeCnt  = 0;
      end else if (tracking) begin
        edgeCnt++;
      end
      if (bus.busy && tracking)
        checkOutput("dut_in_sequence", int'(bus.dut_in), edgeCnt / (SETTLE + 1));
      if (bus.done && !prevDone) begin
        checkOutput("done_latency", edgeCnt, SWEEP);
        if (sbq.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("pass", int'(bus.pass), int'(e.pass));
          checkOutput("fail_count", int'(bus.fail_count), e.fails);
          checkOutput("first_fail_valid", int'(bus.first_fail_valid), int'(e.ffv));
          if (e.ffv)
            checkOutput("first_fail_mt", int'(bus.first_fail_mt), e.ffmt);
          checkOutput("busy_at_done", int'(bus.busy), 0);
        end
        tracking = 1'b0;
      end
      prevBusy = bus.busy;
      prevDone = bus.done;
    end
  end

  task automatic driveEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_dut_in"}, int'(bus.dut_in), 0);
    checkOutput({tag, "_busy"}, int'(bus.busy), 0);
    checkOutput({tag, "_done"}, int'(bus.done), 0);
    checkOutput({tag, "_pass"}, int'(bus.pass), 0);
    checkOutput({tag, "_fail_count"}, int'(bus.fail_count), 0);
    checkOutput({tag, "_first_fail_mt"}, int'(bus.first_fail_mt), 0);
    checkOutput({tag, "_first_fail_valid"}, int'(bus.first_fail_valid), 0);
  endtask

  // One full sweep against gate table tbl; optionally pokes start mid-sweep and
  // checks that a restart from DONE clears the previous verdict on its edge.
  task automatic applyStimulus(input logic [3:0] tbl, input bit midStart, input bit checkClear);
    exp_t       e;
    logic [3:0] diff;
    bit         finished;
    diff    = tbl ^ TRUTH;
    e.fails = $countones(diff);
    e.pass  = (e.fails == 0);
    e.ffv   = (e.fails != 0);
    e.ffmt  = 0;
    for (int m = 3; m >= 0; m--)
      if (diff[m]) e.ffmt = m;
    sbq.push_back(e);
    dutTable = tbl;
    bus.start = 1'b1;
    driveEdge();
    bus.start = 1'b0;
    if (checkClear) begin
      checkOutput("restart_fail_count", int'(bus.fail_count), 0);
      checkOutput("restart_done", int'(bus.done), 0);
      checkOutput("restart_pass", int'(bus.pass), 0);
      checkOutput("restart_first_fail_valid", int'(bus.first_fail_valid), 0);
      checkOutput("restart_busy", int'(bus.busy), 1);
    end
    if (midStart) begin
      repeat (3) driveEdge();
      bus.start = 1'b1;
      driveEdge();
      bus.start = 1'b0;
    end
    finished = 1'b0;
    for (int i = 0; i < 4 * SWEEP; i++) begin
      driveEdge();
      if (sbq.size() == 0) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) begin
      checkOutput("sweep_timeout", 0, 1);
      sbq.delete();
    end
    driveEdge();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    dutTable  = TRUTH;
    repeat (3) driveEdge();
    checkAllZero("reset");
    reset = 1'b0;
    driveEdge();

    applyStimulus(4'b1001, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0110, 1'b0, 1'b0);
    applyStimulus(4'b1101, 1'b0, 1'b0);

    // Start poked during busy must leave the sweep untouched.
    applyStimulus(4'b1001, 1'b1, 1'b0);

    // Failing sweep, then a restart from DONE on a correct gate.
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1001, 1'b0, 1'b1);

    // Reset mid-sweep aborts; nothing was queued for this sweep.
    dutTable  = 4'b0000;
    bus.start = 1'b1;
    driveEdge();
    bus.start = 1'b0;
    repeat (4) driveEdge();
    reset = 1'b1;
    driveEdge();
    reset = 1'b0;
    checkAllZero("midreset");
    repeat (2 * SWEEP) driveEdge();
    checkOutput("midreset_stays_idle_busy", int'(bus.busy), 0);
    checkOutput("midreset_stays_idle_done", int'(bus.done), 0);
    applyStimulus(4'b1001, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++)
      applyStimulus(4'($urandom_range(0, 15)), 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
